// File: rtl/riscv_ifetch.sv
// Instruction fetch: sequential prefetch into a 2-entry FIFO toward decode, with redirect flush.
// Latency: 2 cycles request-to-if_valid, 3 cycles redirect-to-if_valid; 1 instruction/cycle sustained.
// Backpressure: id_ready=0 holds the head stable and stops requests once FIFO plus in-flight reach 2.
// Optional build macro IFETCH_MISALIGN_CHECK_EN: misaligned redirect targets become one fault entry
// and stall fetch until the next redirect; without it target bits [1:0] are cleared and if_fault is 0.
module riscv_ifetch #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter int unsigned         INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  imem_rd_en,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic                  if_fault,
  input  logic                  id_ready
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  fault;
  } entry_t;

  // Architectural state
  entry_t                fifo_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;
  logic                  inflight_q;
  logic [PC_WIDTH-1:0]   inflight_pc_q;
  logic [PC_WIDTH-1:0]   fetch_pc_q;
  logic                  halted_q;

  // Combinational helpers
  entry_t                head;
  entry_t                fault_entry;
  logic                  pop;
  logic                  full;
  logic                  req;
  logic [2:0]            occ_sum;
  logic [PC_WIDTH-1:0]   redirect_tgt;
  logic                  misaligned;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign redirect_tgt = redirect_pc;
  assign misaligned   = (redirect_pc[1:0] != 2'b00);
  assign if_fault     = if_valid & head.fault;
`else
  // Target is forced word-aligned, so the low bits and the stored fault flag are never observed.
  logic unused_bits;
  assign unused_bits  = ^{redirect_pc[1:0], head.fault};
  assign redirect_tgt = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign misaligned   = 1'b0;
  assign if_fault     = 1'b0;
`endif

  // Head presentation, handshake, and request eligibility
  always_comb begin
    head        = fifo_q[rd_ptr_q];
    fault_entry = '0;
    fault_entry.pc    = redirect_pc;
    fault_entry.fault = 1'b1;
    pop         = (count_q != 2'd0) && id_ready;
    full        = (count_q == 2'd2);
    // Slot freed by this cycle's pop is reusable, which keeps one request per cycle in steady state.
    occ_sum     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    // A redirecting cycle issues nothing: its response would be discarded anyway.
    req         = reset_n && !halted_q && !redirect_valid && !full && (occ_sum < 3'd2);
  end

  assign imem_rd_en = req;
  assign imem_addr  = req ? fetch_pc_q : '0;

  assign if_valid = (count_q != 2'd0);
  assign if_inst  = if_valid ? head.inst : '0;
  assign if_pc    = if_valid ? head.pc   : '0;

  // Fetch pointer, in-flight tracking, FIFO update and halt flag; redirect overrides everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      halted_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush queue and drop any response due next cycle; a coincident pop needs no extra handling.
      fetch_pc_q <= redirect_tgt;
      inflight_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      if (misaligned) begin
        fifo_q[0] <= fault_entry;
        wr_ptr_q  <= 1'b1;
        count_q   <= 2'd1;
        halted_q  <= 1'b1;
      end else begin
        wr_ptr_q  <= 1'b0;
        count_q   <= 2'd0;
        halted_q  <= 1'b0;
      end
    end else begin
      inflight_q <= req;
      if (req) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + PC_WIDTH'(4);
      end
      if (inflight_q) begin
        fifo_q[wr_ptr_q].pc    <= inflight_pc_q;
        fifo_q[wr_ptr_q].inst  <= imem_rdata;
        fifo_q[wr_ptr_q].fault <= 1'b0;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_riscv_ifetch.sv
// Bench for riscv_ifetch: directed scenarios plus randomized ready/redirect traffic.
// Reference: program-order PC stream with redirects, fixed redirect/reset timing, and imem returning addr>>2.
// All DUT outputs sampled 1 time unit after the falling edge; inputs driven at the falling edge.
module tb_riscv_ifetch;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_fault;
  logic        id_ready;

  riscv_ifetch #(.PC_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_fault(if_fault),
    .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  // Reference model state
  int          cyc = 0;
  int          red_cyc = -100;
  logic [31:0] red_tgt = '0;
  logic        red_fault = 1'b0;
  logic        model_halted = 1'b0;
  logic        fault_pending = 1'b0;
  logic [31:0] exp_pc = '0;
  logic [31:0] next_req = '0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_redir = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_inst = '0;
  int          ready_run = 0;
  int          stall_reqs = 0;

  // Stimulus selections for the current cycle
  logic        drv_ready = 1'b0;
  logic        drv_redir = 1'b0;
  logic [31:0] drv_tgt = '0;

  task automatic model_reset();
    exp_pc        = RST_PC;
    next_req      = RST_PC;
    model_halted  = 1'b0;
    fault_pending = 1'b0;
    red_fault     = 1'b0;
    red_tgt       = RST_PC;
    prev_valid    = 1'b0;
    prev_req      = 1'b0;
    ready_run     = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, imem_rd_en, 0);
    check({tag, "_addr"},  imem_addr,  0);
    check({tag, "_valid"}, if_valid,   0);
    check({tag, "_inst"},  if_inst,    0);
    check({tag, "_pc"},    if_pc,      0);
    check({tag, "_fault"}, if_fault,   0);
  endtask

  task automatic step_begin();
    @(negedge clk);
    cyc++;
    imem_rdata = prev_req ? mem_word(prev_addr) : $urandom();
  endtask

  task automatic step_end();
    logic [31:0] t;
    id_ready       = drv_ready;
    redirect_valid = drv_redir;
    redirect_pc    = drv_tgt;
    #1;
    // Fixed timing after a redirect (or reset release)
    if (cyc == red_cyc + 1) begin
      if (red_fault) begin
        check("fault_valid", if_valid, 1);
        check("fault_flag", if_fault, 1);
        check("fault_pc", if_pc, red_tgt);
        check("fault_rd_en", imem_rd_en, 0);
      end else begin
        check("redir_n1_valid", if_valid, 0);
        check("redir_n1_rd_en", imem_rd_en, 1);
        check("redir_n1_addr", imem_addr, red_tgt);
      end
    end
    if (cyc == red_cyc + 3 && !red_fault) begin
      check("redir_n3_valid", if_valid, 1);
      check("redir_n3_pc", if_pc, red_tgt);
    end
    // Offered entry must not change while stalled
    if (prev_valid && !prev_ready && !prev_redir) begin
      check("hold_valid", if_valid, 1);
      check("hold_pc", if_pc, prev_pc);
      check("hold_inst", if_inst, prev_inst);
    end
    // Sustained throughput
    ready_run = drv_ready ? ready_run + 1 : 0;
    if (ready_run >= 4 && cyc - red_cyc >= 4 && !model_halted)
      check("throughput_valid", if_valid, 1);
    // Requests follow program order and stop while halted
    if (model_halted) check("halt_no_req", imem_rd_en, 0);
    else if (imem_rd_en) begin
      check("req_addr", imem_addr, next_req);
      next_req = next_req + 32'd4;
    end
    if (imem_rd_en) stall_reqs++;
    // Delivered stream
    if (if_valid && drv_ready) begin
      if (fault_pending) begin
        check("hs_fault_pc", if_pc, red_tgt);
        check("hs_fault_inst", if_inst, 0);
        check("hs_fault_flag", if_fault, 1);
        fault_pending = 1'b0;
      end else begin
        check("hs_pc", if_pc, exp_pc);
        check("hs_inst", if_inst, mem_word(exp_pc));
        check("hs_fault", if_fault, 0);
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (drv_redir) begin
      t = drv_tgt;
      red_cyc = cyc;
`ifdef IFETCH_MISALIGN_CHECK_EN
      if (t[1:0] != 2'b00) begin
        red_fault = 1'b1; fault_pending = 1'b1; model_halted = 1'b1; red_tgt = t;
      end else begin
        red_fault = 1'b0; fault_pending = 1'b0; model_halted = 1'b0; red_tgt = t;
        exp_pc = t; next_req = t;
      end
`else
      t = t & 32'hFFFF_FFFC;
      red_fault = 1'b0; fault_pending = 1'b0; model_halted = 1'b0; red_tgt = t;
      exp_pc = t; next_req = t;
`endif
    end
    prev_valid = if_valid;
    prev_ready = drv_ready;
    prev_redir = drv_redir;
    prev_pc    = if_pc;
    prev_inst  = if_inst;
    prev_req   = imem_rd_en;
    prev_addr  = imem_addr;
  endtask

  // mode: 0 = stalled, 1 = always ready, 2 = random ready with random redirects
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      step_begin();
      drv_ready = (mode == 2) ? ($urandom_range(0, 99) < 70) : (mode == 1);
      drv_redir = 1'b0;
      if (mode == 2 && cyc - red_cyc >= 6 && $urandom_range(0, 99) < 4) begin
        drv_redir = 1'b1;
        drv_tgt   = $urandom();
        if ($urandom_range(0, 7) != 0) drv_tgt[1:0] = 2'b00;
      end
      step_end();
    end
    drv_redir = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] t, input logic rdy);
    step_begin();
    drv_ready = rdy;
    drv_redir = 1'b1;
    drv_tgt   = t;
    step_end();
    drv_redir = 1'b0;
  endtask

  task automatic release_reset();
    step_begin();
    reset_n = 1'b1;
    model_reset();
    red_cyc = cyc - 1;
    step_end();
  endtask

  initial begin
    bit found;
    reset_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_rdata = '0;
    #3;
    check_reset_outputs("rst_init");
    repeat (2) @(posedge clk);

    // Streaming from reset: pcs 0,4,8 back to back, two cycles after the first request
    drv_ready = 1'b1;
    release_reset();
    run(12, 1);

    // Stall then resume
    run(5, 0);
    run(6, 1);

    // Fill the FIFO, then redirect to 0x100 while stalled
    run(4, 0);
    do_redirect(32'h100, 1'b0);
    run(8, 1);

    // Redirect coinciding with the handshake of pc 0x8
    do_redirect(32'h0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step_begin();
      drv_ready = 1'b1;
      if (if_valid && if_pc == 32'h8) begin
        drv_redir = 1'b1;
        drv_tgt   = 32'h40;
        found     = 1'b1;
      end
      step_end();
      drv_redir = 1'b0;
    end
    check("hs_redirect_reached", found, 1);
    run(8, 1);

    // Address wrap
    do_redirect(32'hFFFF_FFF8, 1'b1);
    run(8, 1);

    // Misaligned redirect target
`ifdef IFETCH_MISALIGN_CHECK_EN
    do_redirect(32'h102, 1'b0);
    run(3, 0);
    run(6, 1);
    do_redirect(32'h200, 1'b1);
    run(8, 1);
`else
    do_redirect(32'h102, 1'b1);
    run(8, 1);
`endif

    run(500, 2);

    // Asynchronous reset mid-stream, then restart under stall
    #2;
    reset_n  = 1'b0;
    prev_req = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    stall_reqs = 0;
    drv_ready  = 1'b0;
    release_reset();
    run(4, 0);
    check("stall_reqs_le2", stall_reqs <= 2, 1);
    run(10, 1);

    run(200, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Backstop against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_ifetch.md
RISCV_IFETCH -- requirements
Module: riscv_ifetch

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 32, program-counter width.
REQ-002 The block SHALL have parameter INST_WIDTH, default 32, instruction width.
REQ-003 The block SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port imem_rd_en, output, 1, instruction-memory read request.
REQ-007 Port imem_addr, output, PC_WIDTH, read address, valid with imem_rd_en.
REQ-008 Port imem_rdata, input, INST_WIDTH, read data, valid exactly 1 cycle after imem_rd_en.
REQ-009 Port redirect_valid, input, 1, branch/jump redirect strobe.
REQ-010 Port redirect_pc, input, PC_WIDTH, redirect target.
REQ-011 Port if_valid, output, 1, instruction offered to decode.
REQ-012 Port if_inst, output, INST_WIDTH, offered instruction.
REQ-013 Port if_pc, output, PC_WIDTH, address of if_inst.
REQ-014 Port if_fault, output, 1, offered entry is a fetch fault.
REQ-015 Port id_ready, input, 1, decode accepts; transfer occurs when if_valid and id_ready are both 1.

Function
REQ-016 The block SHALL hold fetch_pc, a 2-entry prefetch FIFO of {pc, inst, fault}, and an in-flight flag.
REQ-017 The block SHALL assert imem_rd_en with imem_addr=fetch_pc only when FIFO occupancy + in-flight count < 2 and the block is not halted; fetch_pc SHALL then advance by 4, wrapping modulo 2^PC_WIDTH.
REQ-018 The block SHALL write imem_rdata with its request address into the FIFO in the response cycle; if_valid SHALL rise the following cycle (request-to-if_valid latency 2 cycles).
REQ-019 The block SHALL present the FIFO head on if_inst/if_pc/if_fault and hold it stable while if_valid=1 and id_ready=0.
REQ-020 With a full FIFO, the block SHALL issue no request; a simultaneous pop and response SHALL keep occupancy unchanged with no loss.
REQ-021 On redirect_valid in cycle N, the block SHALL flush the FIFO, discard any response arriving in N+1, set fetch_pc=redirect_pc, drive if_valid=0 in N+1, request redirect_pc in N+1, and give if_valid in N+3.
REQ-022 A redirect coinciding with a decode handshake SHALL take priority; the handshaken instruction is consumed, all others discarded.
REQ-023 A redirect during the halted state SHALL clear the halt.
REQ-024 Sustained throughput with id_ready=1 SHALL be one instruction per cycle.

Reset
REQ-025 While reset_n=0, the block SHALL drive imem_rd_en=0, imem_addr=0, if_valid=0, if_inst=0, if_pc=0, if_fault=0, with FIFO empty, in-flight clear, halt clear, fetch_pc=RESET_PC.
REQ-026 The block SHALL issue the first request (addr RESET_PC) in the first rising edge after reset_n deasserts.
REQ-027 Reset asserted mid-operation SHALL drop all FIFO contents and in-flight responses immediately.

Configuration
REQ-028 With macro IFETCH_MISALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL enqueue one entry {pc=redirect_pc, inst=0, fault=1}, issue no request, and halt until the next redirect.
REQ-029 Without IFETCH_MISALIGN_CHECK_EN, the block SHALL force redirect_pc[1:0] to 0 and tie if_fault to 0.

Verification
REQ-030 Reset release with id_ready=1, imem returning addr>>2 -> if_pc 0,4,8 on consecutive cycles starting 2 cycles after the first request, with if_inst 0,1,2.
REQ-031 id_ready=0 for 5 cycles -> at most 2 requests issued, if_pc=0 held stable, no instruction lost or duplicated when id_ready returns to 1.
REQ-032 redirect_valid with redirect_pc=0x100 while the FIFO is full -> if_valid=0 next cycle, imem_addr=0x100 next cycle, if_pc=0x100 two cycles later, no stale PC delivered.
REQ-033 redirect simultaneous with a handshake at if_pc=0x8 -> 0x8 consumed once, next delivered if_pc=redirect target.
REQ-034 With IFETCH_MISALIGN_CHECK_EN, redirect_pc=0x102 -> single entry if_fault=1, if_pc=0x102, no imem_rd_en until redirect to 0x200 resumes fetching; without it, fetch resumes at 0x100.
REQ-035 reset_n pulsed low mid-stream -> all outputs 0 asynchronously, fetch restarts at RESET_PC.
